// File: rtl/sr_excitation_driver.sv
// sr_excitation_driver: sequences s/r drive into an SR flop so q reaches a requested level.
// Latency: done pulses H+SETTLE_CYCLES+1 cycles after accept, or 1 cycle if q is already at target.
// Backpressure: one request in flight; req_ready_o is high only in IDLE, and requests are never queued.
module sr_excitation_driver #(
  parameter int SETTLE_CYCLES = 2,
  parameter int HOLD_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_target_i,
  input  logic [HOLD_W-1:0] req_hold_i,
  output logic              s_o,
  output logic              r_o,
  input  logic              q_fb_i,
  input  logic              qbar_fb_i,
  output logic              done_o,
  output logic              ok_o,
  output logic              err_o,
  input  logic              err_clr_i
);

  // One counter serves both the drive window and the settle window.
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int CW = (HOLD_W > SW) ? HOLD_W : SW;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tgt_q, tgt_d;
  logic            s_q, s_d;
  logic            r_q, r_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;

  logic [HOLD_W-1:0] hold_eff;
  logic              fb_at_req;
  logic              fb_at_tgt;

  // A zero hold still drives for one cycle; feedback must be a legal, complementary pair to count as a match.
  always_comb begin
    hold_eff  = (req_hold_i == '0) ? HOLD_W'(1) : req_hold_i;
    fb_at_req = (q_fb_i == req_target_i) && (qbar_fb_i == ~req_target_i);
    fb_at_tgt = (q_fb_i == tgt_q) && (qbar_fb_i == ~tgt_q);
  end

  // Next-state logic; s/r next values derive from the next state so the flop sees registered, never-overlapping drive.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    ok_d    = ok_q;
    err_d   = err_q;

    // Clear first so a failing check below overrides it in the same cycle.
    if (err_clr_i) begin
      err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          tgt_d = req_target_i;
          if (fb_at_req) begin
            state_d = CHECK;
            cnt_d   = '0;
          end else begin
            state_d = DRIVE;
            cnt_d   = CW'(hold_eff) - CW'(1);
          end
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CHECK: begin
        ok_d    = fb_at_tgt;
        if (!fb_at_tgt) begin
          err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    s_d = (state_d == DRIVE) &&  tgt_d;
    r_d = (state_d == DRIVE) && !tgt_d;
  end

  // State and output registers; async reset drops s/r immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  // ok reflects the live check during CHECK and holds the last result afterwards.
  always_comb begin
    req_ready_o = (state_q == IDLE);
    done_o      = (state_q == CHECK);
    ok_o        = (state_q == CHECK) ? fb_at_tgt : ok_q;
    s_o         = s_q;
    r_o         = r_q;
    err_o       = err_q;
  end

endmodule

// File: tb/tb_sr_excitation_driver.sv
// Directed bench for sr_excitation_driver with a behavioural SR flop on the s/r outputs.
// Inputs change and outputs are sampled on the falling clock edge.
// A background monitor checks s/r exclusivity, handshake and done accounting during the random stream.
module tb_sr_excitation_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_target = 1'b0;
  logic [3:0] req_hold = 4'd0;
  logic       s, r;
  logic       q_fb, qbar_fb;
  logic       done, ok, err;
  logic       err_clr = 1'b0;

  // Flop model and feedback override
  logic ff_q;
  logic fb_force = 1'b0;
  logic fb_q = 1'b0;
  logic fb_qbar = 1'b1;

  int vectors = 0;
  int errs    = 0;

  // Capture logs, index k = cycles after accept edge
  logic s_log    [1:16];
  logic r_log    [1:16];
  logic done_log [1:16];
  logic ok_log   [1:16];
  logic rdy_log  [1:16];

  // Monitor state
  logic mon_en = 1'b0;
  logic busy   = 1'b0;
  int   acc_cnt  = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  sr_excitation_driver #(.SETTLE_CYCLES(2), .HOLD_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_target_i (req_target),
    .req_hold_i   (req_hold),
    .s_o          (s),
    .r_o          (r),
    .q_fb_i       (q_fb),
    .qbar_fb_i    (qbar_fb),
    .done_o       (done),
    .ok_o         (ok),
    .err_o        (err),
    .err_clr_i    (err_clr)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) ff_q <= 1'b0;
    else if (s && !r) ff_q <= 1'b1;
    else if (r && !s) ff_q <= 1'b0;
  end

  assign q_fb    = fb_force ? fb_q    : ff_q;
  assign qbar_fb = fb_force ? fb_qbar : ~ff_q;

  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      vectors++;
      if ((s & r) !== 1'b0) begin
        errs++;
        $display("FAIL mon_sr_excl: s=%b r=%b, required not both 1", s, r);
      end
      vectors++;
      if (busy && req_ready) begin
        errs++;
        $display("FAIL mon_ready_busy: req_ready=%b while request in flight, required 0", req_ready);
      end
      vectors++;
      if (!busy && !req_ready) begin
        errs++;
        $display("FAIL mon_ready_idle: req_ready=%b while idle, required 1", req_ready);
      end
      if (done) begin
        done_cnt++;
        vectors++;
        if (!busy) begin
          errs++;
          $display("FAIL mon_done_orphan: done=1 with no accepted request");
        end
        busy = 1'b0;
      end else if (req_valid && req_ready) begin
        busy = 1'b1;
        acc_cnt++;
      end
    end
  end

  task automatic issue(input logic tgt, input logic [3:0] hold);
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      errs++;
      $display("FAIL issue_ready: req_ready=%b, required 1", req_ready);
    end
    req_target = tgt;
    req_hold   = hold;
    req_valid  = 1'b1;
    @(posedge clk);
  endtask

  task automatic capture(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      s_log[k]    = s;
      r_log[k]    = r;
      done_log[k] = done;
      ok_log[k]   = ok;
      rdy_log[k]  = req_ready;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({s, r, req_ready, done, ok, err} !== 6'b001000) begin
      errs++;
      $display("FAIL reset_vals: s,r,rdy,done,ok,err=%b, required 001000", {s, r, req_ready, done, ok, err});
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({s, r, req_ready, done, ok, err} !== 6'b001000) begin
      errs++;
      $display("FAIL post_reset_vals: s,r,rdy,done,ok,err=%b, required 001000", {s, r, req_ready, done, ok, err});
    end
  endtask

  task automatic test_set_hold3();
    issue(1'b1, 4'd3);
    capture(7);
    for (int k = 1; k <= 7; k++) begin
      vectors++;
      if (s_log[k] !== (k <= 3)) begin
        errs++;
        $display("FAIL set3_s k=%0d: s=%b, required %b", k, s_log[k], (k <= 3));
      end
      vectors++;
      if (r_log[k] !== 1'b0) begin
        errs++;
        $display("FAIL set3_r k=%0d: r=%b, required 0", k, r_log[k]);
      end
      vectors++;
      if (done_log[k] !== (k == 6)) begin
        errs++;
        $display("FAIL set3_done k=%0d: done=%b, required %b", k, done_log[k], (k == 6));
      end
      vectors++;
      if (rdy_log[k] !== (k == 7)) begin
        errs++;
        $display("FAIL set3_ready k=%0d: req_ready=%b, required %b", k, rdy_log[k], (k == 7));
      end
    end
    vectors++;
    if (ok_log[6] !== 1'b1) begin
      errs++;
      $display("FAIL set3_ok: ok=%b, required 1", ok_log[6]);
    end
    vectors++;
    if (err !== 1'b0) begin
      errs++;
      $display("FAIL set3_err: err=%b, required 0", err);
    end
    vectors++;
    if (ff_q !== 1'b1) begin
      errs++;
      $display("FAIL set3_flop: q=%b, required 1", ff_q);
    end
  endtask

  task automatic test_at_target();
    issue(1'b1, 4'd5);
    capture(2);
    for (int k = 1; k <= 2; k++) begin
      vectors++;
      if ({s_log[k], r_log[k]} !== 2'b00) begin
        errs++;
        $display("FAIL attgt_sr k=%0d: s,r=%b%b, required 00", k, s_log[k], r_log[k]);
      end
    end
    vectors++;
    if (done_log[1] !== 1'b1 || ok_log[1] !== 1'b1) begin
      errs++;
      $display("FAIL attgt_done: done,ok=%b%b, required 11", done_log[1], ok_log[1]);
    end
    vectors++;
    if (done_log[2] !== 1'b0 || rdy_log[2] !== 1'b1) begin
      errs++;
      $display("FAIL attgt_after: done,rdy=%b%b, required 01", done_log[2], rdy_log[2]);
    end
  endtask

  task automatic test_hold_zero();
    issue(1'b0, 4'd0);
    capture(5);
    for (int k = 1; k <= 5; k++) begin
      vectors++;
      if (r_log[k] !== (k == 1) || s_log[k] !== 1'b0) begin
        errs++;
        $display("FAIL hold0_sr k=%0d: s,r=%b%b, required 0%b", k, s_log[k], r_log[k], (k == 1));
      end
      vectors++;
      if (done_log[k] !== (k == 4)) begin
        errs++;
        $display("FAIL hold0_done k=%0d: done=%b, required %b", k, done_log[k], (k == 4));
      end
    end
    vectors++;
    if (ok_log[4] !== 1'b1 || ff_q !== 1'b0) begin
      errs++;
      $display("FAIL hold0_result: ok,q=%b%b, required 10", ok_log[4], ff_q);
    end
  endtask

  task automatic test_err();
    // q_fb stuck at 0: target 1 fails
    fb_force = 1'b1; fb_q = 1'b0; fb_qbar = 1'b1;
    issue(1'b1, 4'd1);
    capture(5);
    vectors++;
    if (done_log[4] !== 1'b1 || ok_log[4] !== 1'b0) begin
      errs++;
      $display("FAIL err_stuck_check: done,ok=%b%b, required 10", done_log[4], ok_log[4]);
    end
    vectors++;
    if (err !== 1'b1) begin
      errs++;
      $display("FAIL err_stuck_set: err=%b, required 1", err);
    end
    // Release: flop is at 1, passing request keeps err sticky
    fb_force = 1'b0;
    issue(1'b1, 4'd2);
    capture(2);
    vectors++;
    if (done_log[1] !== 1'b1 || ok_log[1] !== 1'b1 || err !== 1'b1) begin
      errs++;
      $display("FAIL err_sticky: done,ok,err=%b%b%b, required 111", done_log[1], ok_log[1], err);
    end
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    vectors++;
    if (err !== 1'b0) begin
      errs++;
      $display("FAIL err_clear: err=%b, required 0", err);
    end
    // Illegal q==qbar feedback, err_clr coincident with the failing CHECK
    fb_force = 1'b1; fb_q = 1'b1; fb_qbar = 1'b1;
    issue(1'b1, 4'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (k == 4) begin
        vectors++;
        if (done !== 1'b1 || ok !== 1'b0) begin
          errs++;
          $display("FAIL err_illegal_check: done,ok=%b%b, required 10", done, ok);
        end
      end
      if (k == 5) begin
        vectors++;
        if (err !== 1'b1 || ok !== 1'b0) begin
          errs++;
          $display("FAIL err_set_wins: err,ok=%b%b, required 10", err, ok);
        end
      end
      err_clr = (k == 4);
    end
    fb_force = 1'b0;
  endtask

  task automatic test_reset_mid();
    int saw_done;
    issue(1'b0, 4'd1);
    capture(5);
    vectors++;
    if (ff_q !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_prep: q=%b, required 0", ff_q);
    end
    issue(1'b1, 4'd8);
    capture(2);
    vectors++;
    if (s_log[2] !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_drive: s=%b, required 1", s_log[2]);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (s !== 1'b0 || r !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_async: s,r=%b%b, required 00", s, r);
    end
    saw_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    vectors++;
    if (saw_done != 0) begin
      errs++;
      $display("FAIL rstmid_nodone: done pulses=%0d, required 0", saw_done);
    end
    vectors++;
    if (req_ready !== 1'b1 || err !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_ready: req_ready,err=%b%b, required 10", req_ready, err);
    end
  endtask

  task automatic test_random();
    int guard;
    busy   = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      guard = 0;
      while (!req_ready && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 40) begin
        vectors++;
        errs++;
        $display("FAIL rand_timeout: req_ready stuck at 0, required 1 within 40 cycles");
        break;
      end
      fb_force   = ($urandom_range(0, 7) == 0);
      fb_q       = 1'($urandom_range(0, 1));
      fb_qbar    = 1'($urandom_range(0, 1));
      req_target = 1'($urandom_range(0, 1));
      req_hold   = 4'($urandom_range(0, 4));
      req_valid  = 1'b1;
      @(negedge clk);
      req_valid  = 1'b0;
    end
    repeat (20) @(negedge clk);
    mon_en   = 1'b0;
    fb_force = 1'b0;
    vectors++;
    if (acc_cnt != 200 || done_cnt != acc_cnt) begin
      errs++;
      $display("FAIL rand_count: accepts=%0d dones=%0d, required 200 each", acc_cnt, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_set_hold3();
    test_at_target();
    test_hold_zero();
    test_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, required completion");
    $fatal(1);
  end

endmodule
